// File: rtl/weight_port_arbiter.sv
// weight_port_arbiter
//   Shares the single synchronous-read port of the weight memory between the
//   host loader (phase 0) and the inference engine's read and write-back
//   channels (phase 1). At most one operation is in flight at a time. Read
//   data and write acknowledgements come back as one-cycle strobes. A
//   starvation counter limits how many write-backs can be granted in a row
//   while a read is waiting.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   phase_infer       0 = host write phase, 1 = inference/learning phase
//   host_we/addr/wdata  host write path, mirrored onto the memory in phase 0
//   rd_req/rd_addr    level read request, held until rd_valid
//   rd_valid/rd_data  read strobe; rd_data holds until the next read
//   wb_req/addr/data  level write-back request, held until wb_ack
//   wb_ack            write-back complete strobe
//   mem_we/addr/wdata registered memory controls
//   mem_rdata         memory read data, valid the cycle after mem_addr
//   busy              high while an operation is in flight
//
// state   | meaning
// IDLE    | no operation in flight, arbitrate in phase 1
// RD_ADDR | read address on the port, memory samples it at the next edge
// RD_DATA | memory read data valid, capture it and pulse rd_valid
// WB_ACK  | write-back presented for one cycle, pulse wb_ack

module weight_port_arbiter #(
   parameter int ADDR_W     = 4,
   parameter int DW         = 8,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              phase_infer,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DW-1:0]     host_wdata,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DW-1:0]     rd_data,
   input  logic              wb_req,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DW-1:0]     wb_data,
   output logic              wb_ack,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata,
   output logic              busy
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_ADDR = 2'd1,
      RD_DATA = 2'd2,
      WB_ACK  = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
   logic              mem_we_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [DW-1:0]     mem_wdata_nxt;
   logic              rd_valid_nxt;
   logic [DW-1:0]     rd_data_nxt;
   logic              wb_ack_nxt;
   logic              grant_rd;
   logic              grant_wb;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         wb_ack     <= 1'b0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_cnt_nxt;
         mem_we     <= mem_we_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
         rd_valid   <= rd_valid_nxt;
         rd_data    <= rd_data_nxt;
         wb_ack     <= wb_ack_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      starve_cnt_nxt = starve_cnt;
      mem_we_nxt     = 1'b0;
      mem_addr_nxt   = mem_addr;
      mem_wdata_nxt  = mem_wdata;
      rd_valid_nxt   = 1'b0;
      rd_data_nxt    = rd_data;
      wb_ack_nxt     = 1'b0;
      grant_rd       = 1'b0;
      grant_wb       = 1'b0;

      if (!phase_infer) begin
         // Host owns the port; anything in flight is dropped without a strobe.
         state_nxt      = IDLE;
         starve_cnt_nxt = '0;
         mem_we_nxt     = host_we;
         mem_addr_nxt   = host_addr;
         mem_wdata_nxt  = host_wdata;
      end else begin
         unique case (state)
            IDLE: begin
               // Write-back wins a tie until the waiting read has been
               // passed over STARVE_MAX times.
               grant_rd = rd_req && (!wb_req || (starve_cnt == STARVE_LIM));
               grant_wb = wb_req && !grant_rd;
               if (grant_rd) begin
                  mem_addr_nxt   = rd_addr;
                  starve_cnt_nxt = '0;
                  state_nxt      = RD_ADDR;
               end else if (grant_wb) begin
                  mem_we_nxt     = 1'b1;
                  mem_addr_nxt   = wb_addr;
                  mem_wdata_nxt  = wb_data;
                  starve_cnt_nxt = rd_req ? starve_cnt + CNT_W'(1) : '0;
                  state_nxt      = WB_ACK;
               end else begin
                  starve_cnt_nxt = '0;
               end
            end
            RD_ADDR: begin
               state_nxt = RD_DATA;
            end
            RD_DATA: begin
               rd_data_nxt  = mem_rdata;
               rd_valid_nxt = 1'b1;
               state_nxt    = IDLE;
            end
            WB_ACK: begin
               wb_ack_nxt = 1'b1;
               state_nxt  = IDLE;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_weight_port_arbiter.sv
// Directed bench for weight_port_arbiter with a behavioural synchronous-read
// weight memory attached to the mem_* port.

module tb_weight_port_arbiter;

   localparam int ADDR_W = 4;
   localparam int DW     = 8;

   logic              clk;
   logic              rst;
   logic              phase_infer;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DW-1:0]     host_wdata;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_valid;
   logic [DW-1:0]     rd_data;
   logic              wb_req;
   logic [ADDR_W-1:0] wb_addr;
   logic [DW-1:0]     wb_data;
   logic              wb_ack;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata;
   logic              busy;

   logic [DW-1:0]     mem [0:15];

   int n_checks = 0;
   int n_pass   = 0;

   weight_port_arbiter #(.ADDR_W(ADDR_W), .DW(DW), .STARVE_MAX(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .phase_infer(phase_infer),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .wb_req     (wb_req),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .wb_ack     (wb_ack),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DW-1:0] exp);
      rd_req  = 1'b1;
      rd_addr = a;
      step();
      check("rd_busy_k", busy, 1);
      check("rd_mem_addr", mem_addr, a);
      check("rd_mem_we", mem_we, 0);
      check("rd_valid_k", rd_valid, 0);
      step();
      check("rd_busy_k1", busy, 1);
      check("rd_valid_k1", rd_valid, 0);
      step();
      check("rd_valid_k2", rd_valid, 1);
      check("rd_data", rd_data, exp);
      check("rd_busy_k2", busy, 0);
      rd_req = 1'b0;
      step();
      check("rd_valid_k3", rd_valid, 0);
      check("rd_data_hold", rd_data, exp);
   endtask

   task automatic do_wb(input logic [ADDR_W-1:0] a, input logic [DW-1:0] d);
      wb_req  = 1'b1;
      wb_addr = a;
      wb_data = d;
      step();
      check("wb_mem_we", mem_we, 1);
      check("wb_mem_addr", mem_addr, a);
      check("wb_mem_wdata", mem_wdata, d);
      check("wb_ack_early", wb_ack, 0);
      step();
      check("wb_mem_we_off", mem_we, 0);
      check("wb_ack", wb_ack, 1);
      check("wb_busy", busy, 0);
      wb_req = 1'b0;
      step();
      check("wb_ack_off", wb_ack, 0);
   endtask

   initial begin
      logic [7:0] grants [0:7];
      int         n_grants;
      logic       prev_busy;

      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      rst         = 1'b1;
      phase_infer = 1'b0;
      host_we     = 1'b1;
      host_addr   = 4'd7;
      host_wdata  = 8'h55;
      rd_req      = 1'b0;
      rd_addr     = '0;
      wb_req      = 1'b0;
      wb_addr     = '0;
      wb_data     = '0;
      step();
      step();
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_wb_ack", wb_ack, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_busy", busy, 0);

      // Host load; engine requests are asserted to show they are ignored.
      rst    = 1'b0;
      rd_req = 1'b1;
      wb_req = 1'b1;
      for (int a = 0; a < 16; a++) begin
         host_we    = 1'b1;
         host_addr  = 4'(a);
         host_wdata = 8'(8'h10 + a);
         step();
         check("p0_mem_we", mem_we, 1);
         check("p0_mem_addr", mem_addr, a);
         check("p0_mem_wdata", mem_wdata, 8'h10 + a);
         check("p0_strobes", {rd_valid, wb_ack, busy}, 0);
      end
      host_we = 1'b0;
      rd_req  = 1'b0;
      wb_req  = 1'b0;
      step();
      check("p0_mem_we_off", mem_we, 0);

      phase_infer = 1'b1;
      step();
      check("p1_idle_busy", busy, 0);
      check("p1_idle_we", mem_we, 0);

      do_read(4'd5, 8'h15);
      do_wb(4'd3, 8'hA5);
      do_read(4'd3, 8'hA5);

      // Both requests held: expect W,W,W,R repeating.
      rd_req    = 1'b1;
      rd_addr   = 4'd9;
      wb_req    = 1'b1;
      wb_addr   = 4'd2;
      wb_data   = 8'h77;
      n_grants  = 0;
      prev_busy = 1'b0;
      for (int c = 0; c < 60 && n_grants < 8; c++) begin
         step();
         if (busy && !prev_busy) begin
            grants[n_grants] = mem_we ? "W" : "R";
            n_grants++;
         end
         if (rd_valid) check("starve_rd_data", rd_data, 8'h19);
         prev_busy = busy;
      end
      check("starve_grant_count", n_grants, 8);
      for (int i = 0; i < 8; i++)
         if (i < n_grants)
            check($sformatf("starve_grant_%0d", i), grants[i], (i % 4 == 3) ? "R" : "W");
      rd_req = 1'b0;
      wb_req = 1'b0;
      step();
      step();
      step();
      check("starve_settle_busy", busy, 0);

      // Abort a read in RD_ADDR by dropping to phase 0 with a host write.
      rd_req  = 1'b1;
      rd_addr = 4'd4;
      step();
      check("abort_busy_k", busy, 1);
      phase_infer = 1'b0;
      rd_req      = 1'b0;
      host_we     = 1'b1;
      host_addr   = 4'd12;
      host_wdata  = 8'hC3;
      step();
      check("abort_busy", busy, 0);
      check("abort_rd_valid", rd_valid, 0);
      check("abort_mem_we", mem_we, 1);
      check("abort_mem_addr", mem_addr, 12);
      check("abort_mem_wdata", mem_wdata, 8'hC3);
      host_we = 1'b0;
      step();
      check("abort_no_late_valid", rd_valid, 0);
      phase_infer = 1'b1;
      step();
      do_read(4'd12, 8'hC3);

      // Reset while in WB_ACK.
      wb_req  = 1'b1;
      wb_addr = 4'd6;
      wb_data = 8'h5A;
      step();
      check("rstwb_mem_we", mem_we, 1);
      rst    = 1'b1;
      wb_req = 1'b0;
      step();
      check("rstwb_wb_ack", wb_ack, 0);
      check("rstwb_outputs", {rd_valid, rd_data, mem_we, mem_addr, mem_wdata, busy}, 0);
      rst = 1'b0;
      step();
      check("rstwb_idle_ack", wb_ack, 0);
      do_read(4'd6, 8'h5A);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
